// File: rtl/ar_outstanding_limiter.sv
// ar_outstanding_limiter: single-entry AR register slice that caps the number
// of read bursts in flight (issued AR without its last R beat). The R channel
// is a pure combinational pass-through.
// Optional statistics ports (stallCycles, peakOutstanding) are present only
// when the macro AR_LIMITER_STATS_EN is defined.
module ar_outstanding_limiter #(
  parameter int ADDR_BITS            = 32,
  parameter int BURST_LEN_WIDTH      = 8,
  parameter int TID_WIDTH            = 8,
  parameter int LOG_BLOCK_DATA_BYTES = 0,
  parameter int OUTST_WIDTH          = 3
) (
  input  logic                                     clk,
  input  logic                                     resetN,
  input  logic                                     en,
  // AR from prefetcher
  input  logic                                     s_ar_valid,
  output logic                                     s_ar_ready,
  input  logic [BURST_LEN_WIDTH-1:0]               s_ar_len,
  input  logic [ADDR_BITS-1:0]                     s_ar_addr,
  input  logic [TID_WIDTH-1:0]                     s_ar_id,
  // AR to memory
  output logic                                     m_ar_valid,
  input  logic                                     m_ar_ready,
  output logic [BURST_LEN_WIDTH-1:0]               m_ar_len,
  output logic [ADDR_BITS-1:0]                     m_ar_addr,
  output logic [TID_WIDTH-1:0]                     m_ar_id,
  // R from memory
  input  logic                                     m_r_valid,
  output logic                                     m_r_ready,
  input  logic                                     m_r_last,
  input  logic [((1<<LOG_BLOCK_DATA_BYTES)*8)-1:0] m_r_data,
  input  logic [TID_WIDTH-1:0]                     m_r_id,
  // R to prefetcher
  output logic                                     s_r_valid,
  input  logic                                     s_r_ready,
  output logic                                     s_r_last,
  output logic [((1<<LOG_BLOCK_DATA_BYTES)*8)-1:0] s_r_data,
  output logic [TID_WIDTH-1:0]                     s_r_id,
  // control / status
  input  logic [OUTST_WIDTH-1:0]                   crs_maxOutstanding,
  output logic [OUTST_WIDTH-1:0]                   outstandingCnt,
  output logic                                     errorFlag
`ifdef AR_LIMITER_STATS_EN
  ,
  output logic [15:0]                              stallCycles,
  output logic [OUTST_WIDTH-1:0]                   peakOutstanding
`endif
);

  typedef enum logic [1:0] {ST_EMPTY, ST_PENDING, ST_BLOCKED} state_t;

  localparam logic [OUTST_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [OUTST_WIDTH-1:0] CNT_ONE = OUTST_WIDTH'(1);

  state_t                       r_state;
  logic                         r_m_ar_valid;
  logic [ADDR_BITS-1:0]         r_addr;
  logic [BURST_LEN_WIDTH-1:0]   r_len;
  logic [TID_WIDTH-1:0]         r_id;
  logic [OUTST_WIDTH-1:0]       r_cnt;
  logic                         r_err;

  logic                         w_m_hs;
  logic                         w_s_ready;
  logic                         w_s_hs;
  logic                         w_r_last;
  logic [OUTST_WIDTH-1:0]       w_cnt_nxt;
  logic                         w_cnt_err;
  logic                         w_limit_hit;

  // R channel is wired straight through
  assign s_r_valid = m_r_valid;
  assign s_r_last  = m_r_last;
  assign s_r_data  = m_r_data;
  assign s_r_id    = m_r_id;
  assign m_r_ready = s_r_ready;

  assign w_m_hs    = r_m_ar_valid & m_ar_ready;
  // Accept when empty, or when the held entry leaves this very cycle so the
  // slice sustains one request per clock. Held low during reset.
  assign w_s_ready = resetN & en & ((r_state == ST_EMPTY) | w_m_hs);
  assign w_s_hs    = s_ar_valid & w_s_ready;
  assign w_r_last  = m_r_valid & s_r_ready & m_r_last;

  assign s_ar_ready     = w_s_ready;
  assign m_ar_valid     = r_m_ar_valid;
  assign m_ar_addr      = r_addr;
  assign m_ar_len       = r_len;
  assign m_ar_id        = r_id;
  assign outstandingCnt = r_cnt;
  assign errorFlag      = r_err;

  // Next outstanding count: issue and completion in one cycle cancel; under/overflow saturate and flag
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_cnt_err = 1'b0;
    if (w_m_hs && !w_r_last) begin
      if (r_cnt == CNT_MAX) w_cnt_err = 1'b1;
      else                  w_cnt_nxt = r_cnt + CNT_ONE;
    end else if (!w_m_hs && w_r_last) begin
      if (r_cnt == '0) w_cnt_err = 1'b1;
      else             w_cnt_nxt = r_cnt - CNT_ONE;
    end
  end

  // Limit is judged against the count as it will be after this edge
  assign w_limit_hit = (crs_maxOutstanding != '0) && (w_cnt_nxt >= crs_maxOutstanding);

  // Outstanding counter and sticky protocol error
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_cnt_err;
    end
  end

  // Request buffer: capture on every accepted AR
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_addr <= '0;
      r_len  <= '0;
      r_id   <= '0;
    end else if (w_s_hs) begin
      r_addr <= s_ar_addr;
      r_len  <= s_ar_len;
      r_id   <= s_ar_id;
    end
  end

  // Slice FSM with registered m_ar_valid; a blocked entry is never presented
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= ST_EMPTY;
      r_m_ar_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_s_hs) begin
            r_state      <= w_limit_hit ? ST_BLOCKED : ST_PENDING;
            r_m_ar_valid <= !w_limit_hit;
          end
        end
        ST_PENDING: begin
          if (w_m_hs) begin
            if (w_s_hs) begin
              r_state      <= w_limit_hit ? ST_BLOCKED : ST_PENDING;
              r_m_ar_valid <= !w_limit_hit;
            end else begin
              r_state      <= ST_EMPTY;
              r_m_ar_valid <= 1'b0;
            end
          end
        end
        ST_BLOCKED: begin
          if (!w_limit_hit) begin
            r_state      <= ST_PENDING;
            r_m_ar_valid <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_EMPTY;
          r_m_ar_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef AR_LIMITER_STATS_EN
  logic [15:0]            r_stall;
  logic [OUTST_WIDTH-1:0] r_peak;

  assign stallCycles     = r_stall;
  assign peakOutstanding = r_peak;

  // Saturating count of blocked cycles and high-water mark of the counter
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_stall <= '0;
      r_peak  <= '0;
    end else begin
      if ((r_state == ST_BLOCKED) && (r_stall != 16'hFFFF)) r_stall <= r_stall + 16'd1;
      if (w_cnt_nxt > r_peak) r_peak <= w_cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_ar_outstanding_limiter.sv
// Self-checking bench for ar_outstanding_limiter: directed scenarios plus a
// randomized run scored against a queue-based behavioural model.
module tb_ar_outstanding_limiter;

  localparam int AW = 32;
  localparam int LW = 8;
  localparam int IW = 8;
  localparam int LB = 0;
  localparam int OW = 3;
  localparam int DW = (1 << LB) * 8;

  logic          clk = 1'b0;
  logic          resetN;
  logic          en;
  logic          s_ar_valid, s_ar_ready;
  logic [LW-1:0] s_ar_len;
  logic [AW-1:0] s_ar_addr;
  logic [IW-1:0] s_ar_id;
  logic          m_ar_valid, m_ar_ready;
  logic [LW-1:0] m_ar_len;
  logic [AW-1:0] m_ar_addr;
  logic [IW-1:0] m_ar_id;
  logic          m_r_valid, m_r_ready, m_r_last;
  logic [DW-1:0] m_r_data;
  logic [IW-1:0] m_r_id;
  logic          s_r_valid, s_r_ready, s_r_last;
  logic [DW-1:0] s_r_data;
  logic [IW-1:0] s_r_id;
  logic [OW-1:0] crs_maxOutstanding;
  logic [OW-1:0] outstandingCnt;
  logic          errorFlag;
`ifdef AR_LIMITER_STATS_EN
  logic [15:0]   stallCycles;
  logic [OW-1:0] peakOutstanding;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic [IW-1:0] i;
  } req_t;

  always #5 clk = ~clk;

  ar_outstanding_limiter #(
    .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW),
    .LOG_BLOCK_DATA_BYTES(LB), .OUTST_WIDTH(OW)
  ) dut (
    .clk(clk), .resetN(resetN), .en(en),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_len(s_ar_len),
    .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_len(m_ar_len),
    .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
    .m_r_data(m_r_data), .m_r_id(m_r_id),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_last(s_r_last),
    .s_r_data(s_r_data), .s_r_id(s_r_id),
    .crs_maxOutstanding(crs_maxOutstanding),
    .outstandingCnt(outstandingCnt), .errorFlag(errorFlag)
`ifdef AR_LIMITER_STATS_EN
    , .stallCycles(stallCycles), .peakOutstanding(peakOutstanding)
`endif
  );

  // one clock, then 1 time unit past the rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b1;
    s_ar_valid = 1'b0; s_ar_addr = '0; s_ar_len = '0; s_ar_id = '0;
    m_ar_ready = 1'b0;
    m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = '0; m_r_id = '0;
    s_r_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    idle_inputs();
    crs_maxOutstanding = '0;
    cyc();
    cyc();
    resetN = 1'b1;
    cyc();
  endtask

  task automatic send_ar(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [LW-1:0] l);
    s_ar_valid = 1'b1; s_ar_addr = a; s_ar_id = id; s_ar_len = l;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    idle_inputs();
    crs_maxOutstanding = '0;
    s_ar_valid = 1'b1;
    m_r_valid = 1'b1; m_r_data = 8'hc3; m_r_id = 8'h11; m_r_last = 1'b1; s_r_ready = 1'b1;
    cyc();
    settle();
    n_checks++; if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_ar_valid: got %b want 0", m_ar_valid); end
    n_checks++; if (s_ar_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ar_ready: got %b want 0", s_ar_ready); end
    n_checks++; if (outstandingCnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", outstandingCnt); end
    n_checks++; if (errorFlag !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", errorFlag); end
    n_checks++; if (m_ar_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", m_ar_addr); end
    n_checks++; if (s_r_data !== 8'hc3 || s_r_id !== 8'h11 || s_r_valid !== 1'b1 || s_r_last !== 1'b1 || m_r_ready !== 1'b1)
      begin n_fail++; $display("FAIL reset_r_pass: got data %h id %h v %b l %b rdy %b want c3 11 1 1 1", s_r_data, s_r_id, s_r_valid, s_r_last, m_r_ready); end
    idle_inputs();
    resetN = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] addrs [3];
    addrs[0] = 32'hbeef; addrs[1] = 32'hbef0; addrs[2] = 32'hbef1;
    do_reset();
    crs_maxOutstanding = 3'd0;
    m_ar_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_ar(addrs[i], IW'(i), 8'd3);
      settle();
      n_checks++; if (s_ar_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_s_ready[%0d]: got %b want 1", i, s_ar_ready); end
      cyc();
      n_checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== addrs[i])
        begin n_fail++; $display("FAIL b2b_issue[%0d]: got v=%b addr=%h want v=1 addr=%h", i, m_ar_valid, m_ar_addr, addrs[i]); end
      n_checks++; if (outstandingCnt !== OW'(i)) begin n_fail++; $display("FAIL b2b_cnt[%0d]: got %0d want %0d", i, outstandingCnt, i); end
    end
    s_ar_valid = 1'b0;
    cyc();
    n_checks++; if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got v=%b want 0", m_ar_valid); end
    n_checks++; if (outstandingCnt !== 3'd3) begin n_fail++; $display("FAIL b2b_final_cnt: got %0d want 3", outstandingCnt); end
  endtask

  task automatic test_limit_block();
    do_reset();
    crs_maxOutstanding = 3'd2;
    m_ar_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      send_ar(32'h100 + AW'(i), IW'(i), 8'd1);
      cyc();
      n_checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'h100 + AW'(i))
        begin n_fail++; $display("FAIL lim_issue[%0d]: got v=%b addr=%h want v=1 addr=%h", i, m_ar_valid, m_ar_addr, 32'h100 + i); end
    end
    send_ar(32'h102, 8'd2, 8'd1);
    cyc();
    send_ar(32'h103, 8'd3, 8'd1);
    settle();
    n_checks++; if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL lim_blocked_valid: got %b want 0", m_ar_valid); end
    n_checks++; if (s_ar_ready !== 1'b0) begin n_fail++; $display("FAIL lim_blocked_ready: got %b want 0", s_ar_ready); end
    n_checks++; if (outstandingCnt !== 3'd2) begin n_fail++; $display("FAIL lim_blocked_cnt: got %0d want 2", outstandingCnt); end
    cyc();
    n_checks++; if (m_ar_valid !== 1'b0 || s_ar_ready !== 1'b0)
      begin n_fail++; $display("FAIL lim_still_blocked: got v=%b rdy=%b want 0 0", m_ar_valid, s_ar_ready); end
    s_ar_valid = 1'b0;
    m_r_valid = 1'b1; m_r_last = 1'b1; s_r_ready = 1'b1;
    cyc();
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = 1'b0;
    n_checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'h102)
      begin n_fail++; $display("FAIL lim_release: got v=%b addr=%h want v=1 addr=102", m_ar_valid, m_ar_addr); end
    n_checks++; if (outstandingCnt !== 3'd1) begin n_fail++; $display("FAIL lim_release_cnt: got %0d want 1", outstandingCnt); end
    cyc();
    n_checks++; if (m_ar_valid !== 1'b0 || outstandingCnt !== 3'd2)
      begin n_fail++; $display("FAIL lim_after_issue: got v=%b cnt=%0d want 0 2", m_ar_valid, outstandingCnt); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    m_ar_ready = 1'b1;
    send_ar(32'h200, 8'd1, 8'd0);
    cyc();
    s_ar_valid = 1'b0;
    cyc();
    n_checks++; if (outstandingCnt !== 3'd1) begin n_fail++; $display("FAIL same_pre_cnt: got %0d want 1", outstandingCnt); end
    send_ar(32'h201, 8'd2, 8'd0);
    cyc();
    s_ar_valid = 1'b0;
    m_r_valid = 1'b1; m_r_last = 1'b1; s_r_ready = 1'b1;
    settle();
    n_checks++; if (m_ar_valid !== 1'b1) begin n_fail++; $display("FAIL same_valid: got %b want 1", m_ar_valid); end
    cyc();
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = 1'b0;
    n_checks++; if (outstandingCnt !== 3'd1 || errorFlag !== 1'b0)
      begin n_fail++; $display("FAIL same_cnt: got cnt=%0d err=%b want 1 0", outstandingCnt, errorFlag); end
  endtask

  task automatic test_underflow_error();
    do_reset();
    m_r_valid = 1'b1; m_r_last = 1'b1; s_r_ready = 1'b1;
    cyc();
    m_r_valid = 1'b0; m_r_last = 1'b0; s_r_ready = 1'b0;
    n_checks++; if (errorFlag !== 1'b1 || outstandingCnt !== 3'd0)
      begin n_fail++; $display("FAIL uflow_set: got err=%b cnt=%0d want 1 0", errorFlag, outstandingCnt); end
    m_ar_ready = 1'b1;
    send_ar(32'h300, 8'd0, 8'd0);
    cyc();
    s_ar_valid = 1'b0;
    cyc();
    cyc();
    n_checks++; if (errorFlag !== 1'b1 || outstandingCnt !== 3'd1)
      begin n_fail++; $display("FAIL uflow_sticky: got err=%b cnt=%0d want 1 1", errorFlag, outstandingCnt); end
    do_reset();
    n_checks++; if (errorFlag !== 1'b0) begin n_fail++; $display("FAIL uflow_cleared: got %b want 0", errorFlag); end
  endtask

  task automatic test_ar_stall();
    do_reset();
    m_ar_ready = 1'b0;
    send_ar(32'hbeef, 8'd5, 8'd3);
    cyc();
    send_ar(32'h1234, 8'd9, 8'd7);
    for (int k = 0; k < 5; k++) begin
      settle();
      n_checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'hbeef || m_ar_id !== 8'd5 || m_ar_len !== 8'd3)
        begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%b a=%h id=%0d len=%0d want 1 beef 5 3", k, m_ar_valid, m_ar_addr, m_ar_id, m_ar_len); end
      n_checks++; if (s_ar_ready !== 1'b0) begin n_fail++; $display("FAIL stall_no_accept[%0d]: got %b want 0", k, s_ar_ready); end
      cyc();
    end
    m_ar_ready = 1'b1;
    settle();
    n_checks++; if (s_ar_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", s_ar_ready); end
    cyc();
    s_ar_valid = 1'b0;
    m_ar_ready = 1'b0;
    n_checks++; if (m_ar_valid !== 1'b1 || m_ar_addr !== 32'h1234 || m_ar_id !== 8'd9)
      begin n_fail++; $display("FAIL stall_next: got v=%b a=%h id=%0d want 1 1234 9", m_ar_valid, m_ar_addr, m_ar_id); end
    n_checks++; if (outstandingCnt !== 3'd1) begin n_fail++; $display("FAIL stall_cnt: got %0d want 1", outstandingCnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    m_ar_ready = 1'b1;
    send_ar(32'h400, 8'd1, 8'd0);
    cyc();
    send_ar(32'h401, 8'd2, 8'd0);
    cyc();
    s_ar_valid = 1'b0;
    m_ar_ready = 1'b0;
    settle();
    n_checks++; if (m_ar_valid !== 1'b1 || outstandingCnt !== 3'd1)
      begin n_fail++; $display("FAIL areset_pre: got v=%b cnt=%0d want 1 1", m_ar_valid, outstandingCnt); end
    #2;
    resetN = 1'b0;
    m_r_valid = 1'b1; m_r_data = 8'h5a;
    #1;
    n_checks++; if (m_ar_valid !== 1'b0 || outstandingCnt !== 3'd0)
      begin n_fail++; $display("FAIL areset_immediate: got v=%b cnt=%0d want 0 0", m_ar_valid, outstandingCnt); end
    n_checks++; if (s_r_data !== 8'h5a || s_r_valid !== 1'b1 || s_ar_ready !== 1'b0)
      begin n_fail++; $display("FAIL areset_r_pass: got data=%h v=%b rdy=%b want 5a 1 0", s_r_data, s_r_valid, s_ar_ready); end
    idle_inputs();
    cyc();
    resetN = 1'b1;
    cyc();
    n_checks++; if (m_ar_valid !== 1'b0 || outstandingCnt !== 3'd0)
      begin n_fail++; $display("FAIL areset_discard: got v=%b cnt=%0d want 0 0", m_ar_valid, outstandingCnt); end
  endtask

  // randomized traffic against a queue model of the one-entry slice
  task automatic test_random(input int cycles, input int rlast_pct);
    req_t q[$];
    bit   presented;
    int   mcnt;
    bit   merr;
    bit   exp_valid, exp_sready, mhs, shs, rl, lim;
    int   nc;
    req_t cur, r;
    do_reset();
    presented = 1'b0;
    mcnt = 0;
    merr = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      exp_valid = (q.size() > 0) && presented;
      n_checks++; if (m_ar_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", c, m_ar_valid, exp_valid); end
      if (exp_valid) begin
        cur = q[0];
        n_checks++; if (m_ar_addr !== cur.a || m_ar_id !== cur.i || m_ar_len !== cur.l)
          begin n_fail++; $display("FAIL rnd_payload@%0d: got %h/%h/%h want %h/%h/%h", c, m_ar_addr, m_ar_id, m_ar_len, cur.a, cur.i, cur.l); end
      end
      n_checks++; if (outstandingCnt !== OW'(mcnt)) begin n_fail++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, outstandingCnt, mcnt); end
      n_checks++; if (errorFlag !== merr) begin n_fail++; $display("FAIL rnd_err@%0d: got %b want %b", c, errorFlag, merr); end

      en         = ($urandom_range(0, 9) != 0);
      s_ar_valid = $urandom_range(0, 1);
      s_ar_addr  = $urandom;
      s_ar_id    = IW'($urandom);
      s_ar_len   = LW'($urandom);
      m_ar_ready = ($urandom_range(0, 3) != 0);
      m_r_valid  = ($urandom_range(0, 99) < rlast_pct * 2);
      m_r_last   = $urandom_range(0, 1);
      s_r_ready  = ($urandom_range(0, 3) != 0);
      m_r_data   = DW'($urandom);
      m_r_id     = IW'($urandom);
      if ($urandom_range(0, 39) == 0) crs_maxOutstanding = OW'($urandom_range(0, 7));
      settle();

      exp_sready = en && ((q.size() == 0) || (exp_valid && m_ar_ready));
      n_checks++; if (s_ar_ready !== exp_sready) begin n_fail++; $display("FAIL rnd_s_ready@%0d: got %b want %b", c, s_ar_ready, exp_sready); end
      n_checks++; if (s_r_data !== m_r_data || m_r_ready !== s_r_ready || s_r_valid !== m_r_valid)
        begin n_fail++; $display("FAIL rnd_r_pass@%0d: got %h/%b/%b want %h/%b/%b", c, s_r_data, m_r_ready, s_r_valid, m_r_data, s_r_ready, m_r_valid); end

      mhs = exp_valid && m_ar_ready;
      shs = s_ar_valid && exp_sready;
      rl  = m_r_valid && s_r_ready && m_r_last;
      nc  = mcnt + int'(mhs) - int'(rl);
      if (nc < 0) begin nc = 0; merr = 1'b1; end
      if (nc > (1 << OW) - 1) begin nc = (1 << OW) - 1; merr = 1'b1; end
      lim = (crs_maxOutstanding != 0) && (nc >= int'(crs_maxOutstanding));
      if (mhs) void'(q.pop_front());
      if (shs) begin
        r.a = s_ar_addr; r.i = s_ar_id; r.l = s_ar_len;
        q.push_back(r);
        presented = !lim;
      end else if (q.size() > 0 && !presented && !lim) begin
        presented = 1'b1;
      end
      mcnt = nc;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    idle_inputs();
    crs_maxOutstanding = '0;
    test_reset();
    test_back_to_back();
    test_limit_block();
    test_same_cycle();
    test_underflow_error();
    test_ar_stall();
    test_async_reset();
    test_random(600, 15);
    test_random(600, 30);
    test_random(600, 45);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
